// File: rtl/mixer_cic.sv
// mixer_cic: 1-bit RF I/Q down-mixer followed by a 3rd-order CIC decimator.
//
// The 1-bit RF sample is XNOR-mixed against the square-wave LO sine/cosine
// into +/-1 products. Each channel then goes through three integrators at
// the input rate and three combs at the decimated rate, all W = 2+3*log2(R)
// bits wide with two's-complement wrap-around. The result is reduced to
// DATA_WIDTH bits and presented on a valid/ready output.
//
// Optional build macro:
//   MIXER_CIC_ROUND_EN  round-half-up with positive saturation instead of
//                       plain truncation when reducing to DATA_WIDTH bits.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   rf_in      1-bit comparator / sigma-delta RF sample
//   lo_sin     NCO square-wave sine
//   lo_cos     NCO square-wave cosine
//   out_ready  downstream can accept a sample
//   i_out      signed in-phase sample (DATA_WIDTH)
//   q_out      signed quadrature sample (DATA_WIDTH)
//   out_valid  i_out/q_out hold a sample not yet accepted
//   overrun    sticky: an unaccepted sample was overwritten

module mixer_cic #(
  parameter int DECIMATION = 4096,
  parameter int DATA_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rf_in,
  input  logic                         lo_sin,
  input  logic                         lo_cos,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int LOG2R = $clog2(DECIMATION);
  localparam int W     = 2 + 3 * LOG2R;
  localparam int CW    = LOG2R;
  localparam logic [CW-1:0] CNT_MAX = CW'(DECIMATION - 1);

  if (DECIMATION < 4 || DECIMATION > 65536 ||
      (DECIMATION & (DECIMATION - 1)) != 0) begin : g_bad_decimation
    $error("mixer_cic: DECIMATION must be a power of two in 4..65536");
  end
  if (DATA_WIDTH < 4 || DATA_WIDTH > 24 || DATA_WIDTH > W) begin : g_bad_width
    $error("mixer_cic: DATA_WIDTH must be 4..24 and not exceed W");
  end

  // Channel index 0 = I (mixed with cosine), 1 = Q (mixed with sine).
  logic signed [1:0]   mix      [2];
  logic signed [W-1:0] int1     [2];
  logic signed [W-1:0] int2     [2];
  logic signed [W-1:0] int3     [2];
  logic signed [W-1:0] samp     [2];
  logic signed [W-1:0] dly1     [2];
  logic signed [W-1:0] dly2     [2];
  logic signed [W-1:0] dly3     [2];
  logic signed [W-1:0] comb_res [2];

  logic signed [W-1:0]          comb1 [2];
  logic signed [W-1:0]          comb2 [2];
  logic signed [W-1:0]          comb3 [2];
  logic signed [DATA_WIDTH-1:0] red   [2];

  logic [CW-1:0] dec_cnt;
  logic          strobe;
  logic          comb_go;
  logic          out_go;

  assign strobe = (dec_cnt == CNT_MAX);

`ifdef MIXER_CIC_ROUND_EN
  localparam int RSH = (W > DATA_WIDTH) ? (W - DATA_WIDTH - 1) : 0;
  // Half an output LSB; zero when no bits are dropped.
  localparam logic signed [W-1:0] RND = (W > DATA_WIDTH) ? (W'(1) << RSH) : '0;
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic signed [W-1:0] rnd [2];
  logic                unused_rnd;
  assign unused_rnd = ^{rnd[0], rnd[1]};
`else
  logic unused_trunc;
  assign unused_trunc = ^{comb_res[0], comb_res[1]};
`endif

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      comb1[c] = samp[c] - dly1[c];
      comb2[c] = comb1[c] - dly2[c];
      comb3[c] = comb2[c] - dly3[c];
`ifdef MIXER_CIC_ROUND_EN
      rnd[c] = comb_res[c] + RND;
      // Only a non-negative value can overflow when adding a positive offset.
      if (!comb_res[c][W-1] && rnd[c][W-1]) begin
        red[c] = SAT_MAX;
      end else begin
        red[c] = rnd[c][W-1 -: DATA_WIDTH];
      end
`else
      red[c] = comb_res[c][W-1 -: DATA_WIDTH];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        mix[c]      <= '0;
        int1[c]     <= '0;
        int2[c]     <= '0;
        int3[c]     <= '0;
        samp[c]     <= '0;
        dly1[c]     <= '0;
        dly2[c]     <= '0;
        dly3[c]     <= '0;
        comb_res[c] <= '0;
      end
      dec_cnt   <= '0;
      comb_go   <= 1'b0;
      out_go    <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix[0] <= (rf_in == lo_cos) ? 2'sb01 : 2'sb11;
      mix[1] <= (rf_in == lo_sin) ? 2'sb01 : 2'sb11;

      for (int c = 0; c < 2; c++) begin
        int1[c] <= int1[c] + {{(W-2){mix[c][1]}}, mix[c]};
        int2[c] <= int2[c] + int1[c];
        int3[c] <= int3[c] + int2[c];
        if (strobe) begin
          samp[c] <= int3[c];
        end
        if (comb_go) begin
          dly1[c]     <= samp[c];
          dly2[c]     <= comb1[c];
          dly3[c]     <= comb2[c];
          comb_res[c] <= comb3[c];
        end
      end

      dec_cnt <= strobe ? '0 : dec_cnt + 1'b1;
      comb_go <= strobe;
      out_go  <= comb_go;

      // A fresh sample always wins; overwriting an unaccepted one is flagged.
      if (out_go) begin
        i_out     <= red[0];
        q_out     <= red[1];
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mixer_cic.sv
// Directed bench for mixer_cic with DECIMATION=16, DATA_WIDTH=8 (W=14).
// Edge numbering: edge 1 is the first rising edge with rst low.
// With rf=lo_sin=lo_cos=1 the truncated outputs are 5, 46, 63, 64, 64, ...
// (comb values 364, 2968, 4092, 4096 from the step response of the CIC).

module tb_mixer_cic;

  logic       clk = 1'b0;
  logic       rst;
  logic       rf_in;
  logic       lo_sin;
  logic       lo_cos;
  logic       out_ready;
  logic [7:0] i_out;
  logic [7:0] q_out;
  logic       out_valid;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  mixer_cic #(
    .DECIMATION(16),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rf_in     (rf_in),
    .lo_sin    (lo_sin),
    .lo_cos    (lo_cos),
    .out_ready (out_ready),
    .i_out     (i_out),
    .q_out     (q_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_in = 1'b1; lo_sin = 1'b1; lo_cos = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_overrun got=%b want=0", overrun);
    end
    n_cmp++;
    if ({i_out, q_out} !== 16'h0000) begin
      n_err++; $display("FAIL reset_data got i=%h q=%h want 00 00", i_out, q_out);
    end
  endtask

  task automatic test_timing();
    logic exp_v;
    rf_in = 1'b1; lo_sin = 1'b1; lo_cos = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 70; e++) begin
      tick();
      exp_v = (e >= 18) && (((e - 18) % 16) == 0);
      n_cmp++;
      if (out_valid !== exp_v) begin
        n_err++; $display("FAIL timing_valid edge=%0d got=%b want=%b", e, out_valid, exp_v);
      end
      if (e == 18) begin
        n_cmp++;
        if ({i_out, q_out} !== {8'd5, 8'd5}) begin
          n_err++; $display("FAIL step_s1 got i=%0d q=%0d want 5 5", $signed(i_out), $signed(q_out));
        end
      end
      if (e == 34) begin
        n_cmp++;
        if ({i_out, q_out} !== {8'd46, 8'd46}) begin
          n_err++; $display("FAIL step_s2 got i=%0d q=%0d want 46 46", $signed(i_out), $signed(q_out));
        end
      end
      if (e == 50) begin
        n_cmp++;
        if ({i_out, q_out} !== {8'd63, 8'd63}) begin
          n_err++; $display("FAIL step_s3 got i=%0d q=%0d want 63 63", $signed(i_out), $signed(q_out));
        end
      end
      if (e == 66) begin
        n_cmp++;
        if ({i_out, q_out} !== {8'd64, 8'd64}) begin
          n_err++; $display("FAIL dc_plus got i=%0d q=%0d want 64 64", $signed(i_out), $signed(q_out));
        end
      end
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL timing_overrun got=%b want=0", overrun);
    end
  endtask

  task automatic test_iq_opposite();
    int nv;
    nv = 0;
    rf_in = 1'b0; lo_sin = 1'b1; lo_cos = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      tick();
      if (out_valid === 1'b1) begin
        nv++;
        if (nv >= 4) begin
          n_cmp++;
          if ({i_out, q_out} !== {8'd64, 8'hC0}) begin
            n_err++; $display("FAIL iq_opposite n=%0d got i=%0d q=%0d want 64 -64",
                              nv, $signed(i_out), $signed(q_out));
          end
        end
      end
    end
    n_cmp++;
    if (nv !== 5) begin
      n_err++; $display("FAIL iq_opposite_count got=%0d want=5", nv);
    end
  endtask

  task automatic test_toggle();
    int nv;
    nv = 0;
    rf_in = 1'b0; lo_sin = 1'b1; lo_cos = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      rf_in = ~rf_in;
      tick();
      if (out_valid === 1'b1) begin
        nv++;
        if (nv >= 4) begin
          n_cmp++;
          if ({i_out, q_out} !== 16'h0000) begin
            n_err++; $display("FAIL toggle_zero n=%0d got i=%0d q=%0d want 0 0",
                              nv, $signed(i_out), $signed(q_out));
          end
        end
      end
    end
    n_cmp++;
    if (nv !== 5) begin
      n_err++; $display("FAIL toggle_count got=%0d want=5", nv);
    end
  endtask

  task automatic test_overrun_and_reset();
    rf_in = 1'b1; lo_sin = 1'b1; lo_cos = 1'b1; out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 58; e++) begin
      tick();
      case (e)
        17: begin
          n_cmp++;
          if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL ovr_early_valid got=%b want=0", out_valid);
          end
        end
        18: begin
          n_cmp++;
          if ({out_valid, overrun, i_out} !== {1'b1, 1'b0, 8'd5}) begin
            n_err++; $display("FAIL ovr_first got v=%b o=%b i=%0d want 1 0 5",
                              out_valid, overrun, $signed(i_out));
          end
        end
        26: begin
          n_cmp++;
          if ({out_valid, i_out, q_out} !== {1'b1, 8'd5, 8'd5}) begin
            n_err++; $display("FAIL ovr_hold got v=%b i=%0d q=%0d want 1 5 5",
                              out_valid, $signed(i_out), $signed(q_out));
          end
        end
        34: begin
          n_cmp++;
          if ({out_valid, overrun, i_out, q_out} !== {1'b1, 1'b1, 8'd46, 8'd46}) begin
            n_err++; $display("FAIL ovr_overwrite got v=%b o=%b i=%0d q=%0d want 1 1 46 46",
                              out_valid, overrun, $signed(i_out), $signed(q_out));
          end
          out_ready = 1'b1;
        end
        35: begin
          n_cmp++;
          if ({out_valid, overrun} !== 2'b01) begin
            n_err++; $display("FAIL ovr_accept got v=%b o=%b want 0 1", out_valid, overrun);
          end
          out_ready = 1'b0;
        end
        50: begin
          n_cmp++;
          if ({out_valid, overrun, i_out} !== {1'b1, 1'b1, 8'd63}) begin
            n_err++; $display("FAIL ovr_third got v=%b o=%b i=%0d want 1 1 63",
                              out_valid, overrun, $signed(i_out));
          end
        end
        default: ;
      endcase
    end
    // Decimation counter is 10 here; reset overrides a concurrent out_ready.
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, overrun, i_out, q_out} !== 18'd0) begin
      n_err++; $display("FAIL midreset_clear got v=%b o=%b i=%h q=%h want all 0",
                        out_valid, overrun, i_out, q_out);
    end
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL midreset_early got=%b want=0", out_valid);
        end
      end
      if (k == 18) begin
        n_cmp++;
        if ({out_valid, overrun, i_out} !== {1'b1, 1'b0, 8'd5}) begin
          n_err++; $display("FAIL midreset_restart got v=%b o=%b i=%0d want 1 0 5",
                            out_valid, overrun, $signed(i_out));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_iq_opposite();
    test_toggle();
    test_overrun_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
